// File: rtl/video_pkg.sv
// Shared timing description and the default 640x480@60 raster constants.
package video_pkg;

    // One axis of a raster: visible span followed by front porch, sync and back porch.
    typedef struct packed {
        int unsigned active;
        int unsigned front;
        int unsigned sync;
        int unsigned back;
    } timing_t;

    localparam timing_t H_DEFAULT = '{active: 640, front: 16, sync: 96, back: 48};
    localparam timing_t V_DEFAULT = '{active: 480, front: 10, sync: 2,  back: 33};

    // Total counts per axis (pixels per line or lines per frame).
    function automatic int unsigned t_total(timing_t t);
        return t.active + t.front + t.sync + t.back;
    endfunction

    // First count of the sync window.
    function automatic int unsigned sync_start(timing_t t);
        return t.active + t.front;
    endfunction

    // First count past the sync window.
    function automatic int unsigned sync_end(timing_t t);
        return t.active + t.front + t.sync;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Control inputs and raster outputs of the timing generator.
interface video_timing_gen_if #(
    parameter int unsigned X_WIDTH = 11,
    parameter int unsigned Y_WIDTH = 10
);
    logic               ce;
    logic [Y_WIDTH-1:0] line_cmp;
    logic [X_WIDTH-1:0] x;
    logic [Y_WIDTH-1:0] y;
    logic               active;
    logic               hsync;
    logic               vsync;
    logic               blank_n;
    logic               frame_start;
    logic               line_start;
    logic               line_irq;
    logic [15:0]        frame_count;

    modport master (
        input  ce, line_cmp,
        output x, y, active, hsync, vsync, blank_n,
               frame_start, line_start, line_irq, frame_count
    );

    modport slave (
        output ce, line_cmp,
        input  x, y, active, hsync, vsync, blank_n,
               frame_start, line_start, line_irq, frame_count
    );
endinterface

// File: rtl/video_timing_gen_sync_delay_line.sv
// ce-qualified shift register: output register plus DEPTH extra stages.
module sync_delay_line #(
    parameter int unsigned      WIDTH   = 3,
    parameter int unsigned      DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ce_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);
    logic [WIDTH-1:0] stage_q [0:DEPTH];

    // Shift one position per ce step; stage 0 doubles as the output register when DEPTH=0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i <= DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else if (ce_i) begin
            stage_q[0] <= din_i;
            for (int unsigned i = 1; i <= DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout_o = stage_q[DEPTH];
endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: counters, sync/blank with programmable delay, line/frame events.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = H_DEFAULT.active,
    parameter int unsigned H_FRONT    = H_DEFAULT.front,
    parameter int unsigned H_SYNC     = H_DEFAULT.sync,
    parameter int unsigned H_BACK     = H_DEFAULT.back,
    parameter int unsigned V_ACTIVE   = V_DEFAULT.active,
    parameter int unsigned V_FRONT    = V_DEFAULT.front,
    parameter int unsigned V_SYNC     = V_DEFAULT.sync,
    parameter int unsigned V_BACK     = V_DEFAULT.back,
    parameter bit          HSYNC_POL  = 1'b0,
    parameter bit          VSYNC_POL  = 1'b0,
    parameter int unsigned X_WIDTH    = 11,
    parameter int unsigned Y_WIDTH    = 10,
    parameter int unsigned PIPE_DELAY = 2
) (
    input  logic              clock,
    input  logic              reset,
    video_timing_gen_if.master vif
);
    localparam timing_t     H_T      = '{active: H_ACTIVE, front: H_FRONT, sync: H_SYNC, back: H_BACK};
    localparam timing_t     V_T      = '{active: V_ACTIVE, front: V_FRONT, sync: V_SYNC, back: V_BACK};
    localparam int unsigned H_TOTAL  = t_total(H_T);
    localparam int unsigned V_TOTAL  = t_total(V_T);
    localparam int unsigned HS_START = sync_start(H_T);
    localparam int unsigned HS_END   = sync_end(H_T);
    localparam int unsigned VS_START = sync_start(V_T);
    localparam int unsigned VS_END   = sync_end(V_T);
    localparam logic [2:0]  SYNC_RST = {~HSYNC_POL, ~VSYNC_POL, 1'b0};

    logic [X_WIDTH-1:0] h_q, h_d;
    logic [Y_WIDTH-1:0] v_q, v_d;
    logic [X_WIDTH-1:0] x_q;
    logic [Y_WIDTH-1:0] y_q;
    logic               active_q;
    logic               line_start_q, frame_start_q, line_irq_q;
    logic [15:0]        frame_count_q, frame_count_d;
    logic               active_c, hs_act_c, vs_act_c;
    logic               line_start_c, frame_start_c, line_irq_c;
    logic [2:0]         sync_raw_c, sync_dly;

    // Next counter position and everything decoded from it.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (vif.ce) begin
            if (h_q == X_WIDTH'(H_TOTAL - 1)) begin
                h_d = '0;
                v_d = (v_q == Y_WIDTH'(V_TOTAL - 1)) ? '0 : v_q + Y_WIDTH'(1);
            end else begin
                h_d = h_q + X_WIDTH'(1);
            end
        end
        active_c      = (32'(h_d) < H_ACTIVE) && (32'(v_d) < V_ACTIVE);
        hs_act_c      = (32'(h_d) >= HS_START) && (32'(h_d) < HS_END);
        vs_act_c      = (32'(v_d) >= VS_START) && (32'(v_d) < VS_END);
        line_start_c  = vif.ce && (h_d == '0);
        frame_start_c = line_start_c && (v_d == '0);
        line_irq_c    = line_start_c && (v_d == vif.line_cmp);
        frame_count_d = frame_start_c ? frame_count_q + 16'd1 : frame_count_q;
        sync_raw_c    = {~(hs_act_c ^ HSYNC_POL), ~(vs_act_c ^ VSYNC_POL), active_c};
    end

    // Counters and undelayed outputs; reset parks counters so the first ce lands on (0,0).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            h_q           <= X_WIDTH'(H_TOTAL - 1);
            v_q           <= Y_WIDTH'(V_TOTAL - 1);
            x_q           <= '0;
            y_q           <= '0;
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            line_irq_q    <= 1'b0;
            frame_count_q <= '0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            line_start_q  <= line_start_c;
            frame_start_q <= frame_start_c;
            line_irq_q    <= line_irq_c;
            frame_count_q <= frame_count_d;
            if (vif.ce) begin
                x_q      <= h_d;
                y_q      <= v_d;
                active_q <= active_c;
            end
        end
    end

    sync_delay_line #(
        .WIDTH   (3),
        .DEPTH   (PIPE_DELAY),
        .RST_VAL (SYNC_RST)
    ) u_sync_delay (
        .clock  (clock),
        .reset  (reset),
        .ce_i   (vif.ce),
        .din_i  (sync_raw_c),
        .dout_o (sync_dly)
    );

    assign vif.x           = x_q;
    assign vif.y           = y_q;
    assign vif.active      = active_q;
    assign vif.hsync       = sync_dly[2];
    assign vif.vsync       = sync_dly[1];
    assign vif.blank_n     = sync_dly[0];
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;
    assign vif.line_irq    = line_irq_q;
    assign vif.frame_count = frame_count_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a 14x7 raster: delay 0, delay 2 and inverted polarity.
module tb_video_timing_gen;
    localparam int unsigned XW = 4;
    localparam int unsigned YW = 4;
    localparam int HT = 14;
    localparam int VT = 7;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          ce;
    logic [YW-1:0] line_cmp;

    always #5 clock = ~clock;

    video_timing_gen_if #(.X_WIDTH(XW), .Y_WIDTH(YW)) if0 ();
    video_timing_gen_if #(.X_WIDTH(XW), .Y_WIDTH(YW)) if2 ();
    video_timing_gen_if #(.X_WIDTH(XW), .Y_WIDTH(YW)) ifp ();

    assign if0.ce = ce;  assign if0.line_cmp = line_cmp;
    assign if2.ce = ce;  assign if2.line_cmp = line_cmp;
    assign ifp.ce = ce;  assign ifp.line_cmp = line_cmp;

    video_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .X_WIDTH(XW), .Y_WIDTH(YW), .PIPE_DELAY(0)
    ) dut0 (.clock(clock), .reset(reset), .vif(if0));

    video_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .X_WIDTH(XW), .Y_WIDTH(YW), .PIPE_DELAY(2)
    ) dut2 (.clock(clock), .reset(reset), .vif(if2));

    video_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
        .X_WIDTH(XW), .Y_WIDTH(YW), .PIPE_DELAY(0)
    ) dutp (.clock(clock), .reset(reset), .vif(ifp));

    typedef struct {
        int x, y, act, fs, ls, irq, fc;
        int hs0, vs0, bl0, hs2, vs2, bl2, hsp, vsp;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_fs = -1;
    int exp_period = 0;
    int irq_cnt = 0;

    // Reference model state
    int mh, mv, mfc, ex, ey, eact;
    int hist_hs[3], hist_vs[3], hist_bl[3];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance the model by one clock edge with the currently driven inputs and queue its outputs.
    task automatic model_edge();
        exp_t e;
        int ls, fs, irq;
        ls = 0; fs = 0; irq = 0;
        if (!reset) begin
            mh = HT - 1; mv = VT - 1; mfc = 0;
            ex = 0; ey = 0; eact = 0;
            for (int i = 0; i < 3; i++) begin
                hist_hs[i] = 0; hist_vs[i] = 0; hist_bl[i] = 0;
            end
        end else if (ce) begin
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            ex = mh; ey = mv;
            eact = (mh < 8 && mv < 4) ? 1 : 0;
            for (int i = 2; i > 0; i--) begin
                hist_hs[i] = hist_hs[i-1]; hist_vs[i] = hist_vs[i-1]; hist_bl[i] = hist_bl[i-1];
            end
            hist_hs[0] = (mh == 10 || mh == 11) ? 1 : 0;
            hist_vs[0] = (mv == 5) ? 1 : 0;
            hist_bl[0] = eact;
            ls  = (mh == 0) ? 1 : 0;
            fs  = (ls == 1 && mv == 0) ? 1 : 0;
            irq = (ls == 1 && mv == int'(line_cmp)) ? 1 : 0;
            if (fs == 1) mfc = (mfc + 1) & 32'hFFFF;
        end
        e.x = ex; e.y = ey; e.act = eact;
        e.fs = fs; e.ls = ls; e.irq = irq; e.fc = mfc;
        e.hs0 = 1 - hist_hs[0]; e.vs0 = 1 - hist_vs[0]; e.bl0 = hist_bl[0];
        e.hs2 = 1 - hist_hs[2]; e.vs2 = 1 - hist_vs[2]; e.bl2 = hist_bl[2];
        e.hsp = hist_hs[0];     e.vsp = hist_vs[0];
        sb.push_back(e);
    endtask

    // Pop the expectation for the edge just taken and compare every DUT against it.
    task automatic compare_pop();
        exp_t e;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check_eq("x",           32'(if0.x),           32'(e.x));
        check_eq("y",           32'(if0.y),           32'(e.y));
        check_eq("active",      32'(if0.active),      32'(e.act));
        check_eq("hsync",       32'(if0.hsync),       32'(e.hs0));
        check_eq("vsync",       32'(if0.vsync),       32'(e.vs0));
        check_eq("blank_n",     32'(if0.blank_n),     32'(e.bl0));
        check_eq("frame_start", 32'(if0.frame_start), 32'(e.fs));
        check_eq("line_start",  32'(if0.line_start),  32'(e.ls));
        check_eq("line_irq",    32'(if0.line_irq),    32'(e.irq));
        check_eq("frame_count", 32'(if0.frame_count), 32'(e.fc));
        check_eq("d2_x",        32'(if2.x),           32'(e.x));
        check_eq("d2_y",        32'(if2.y),           32'(e.y));
        check_eq("d2_hsync",    32'(if2.hsync),       32'(e.hs2));
        check_eq("d2_vsync",    32'(if2.vsync),       32'(e.vs2));
        check_eq("d2_blank_n",  32'(if2.blank_n),     32'(e.bl2));
        check_eq("pol_hsync",   32'(ifp.hsync),       32'(e.hsp));
        check_eq("pol_vsync",   32'(ifp.vsync),       32'(e.vsp));
        if (if0.line_irq === 1'b1) irq_cnt++;
        if (if0.frame_start === 1'b1) begin
            if (last_fs >= 0 && exp_period > 0)
                check_eq("frame_period", 32'(cyc - last_fs), 32'(exp_period));
            last_fs = cyc;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
        cyc++;
        compare_pop();
    endtask

    initial begin
        int n;
        ce = 1'b1;
        line_cmp = YW'(2);
        #1;

        // Held in reset with ce active
        repeat (4) tick();

        // Free-running, ce tied high, line_cmp=2
        reset = 1'b1;
        exp_period = 98; last_fs = -1;
        repeat (2 * 98 + 10) tick();

        // line_cmp=6 fires on the last line
        line_cmp = YW'(6);
        repeat (98) tick();

        // line_cmp beyond V_TOTAL never fires
        line_cmp = YW'(9);
        irq_cnt = 0;
        repeat (98) tick();
        check_eq("irq_never", 32'(irq_cnt), 32'd0);

        // ce on every third clock
        line_cmp = YW'(2);
        exp_period = 294; last_fs = -1;
        for (int i = 0; i < 2 * 294 + 20; i++) begin
            ce = (i % 3 == 0);
            tick();
        end

        // Run to (5,3), then reset mid-frame for 4 clocks
        ce = 1'b1; exp_period = 0;
        n = 0;
        while (!(mh == 5 && mv == 3) && n < 200) begin
            tick();
            n++;
        end
        check_eq("reach_5_3", 32'(n < 200), 32'd1);
        reset = 1'b0;
        repeat (4) tick();

        // Release with ce low: reset values must hold until the first ce
        ce = 1'b0;
        reset = 1'b1;
        repeat (2) tick();
        ce = 1'b1;
        exp_period = 98; last_fs = -1;
        repeat (110) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
